rx_phase_slicer: RTL and testbench
==================================

Name: rx_phase_slicer

Overview:
- Receive-side counterpart of the polyphase raised-cosine TX filter: consumes the OS-times-oversampled filtered stream, one sample per valid cycle.
- Downsamples to symbol rate at a selected phase and slices each kept sample to a bit.
- Includes a block-energy timing estimator that picks the sampling phase with maximum accumulated |sample| over a window of symbols.
- Sits between the (channel-impaired) filter output and the BER/prbs checker.

Parameters:
- OS, 4, oversampling factor; must equal the TX filter OS.
- S_IN, 10, signed input sample width; matches the TX filter output width.
- N_SYM_LOG2, 10, log2 of the estimation window in symbols.
- S_PH, $clog2(OS), phase index width (derived).
- S_ACC, S_IN+N_SYM_LOG2, unsigned energy accumulator width (derived).

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  block enable; low = synchronous clear of datapath.
- i_valid  in  1  qualifies i_sample.
- i_sample  in  S_IN  signed filtered sample.
- i_phase_mode  in  1  0 = auto (estimated phase), 1 = manual.
- i_phase_man  in  S_PH  manual sampling phase.
- o_bit  out  1  sliced bit: 1 when kept sample < 0, else 0.
- o_valid  out  1  one-cycle pulse per decided symbol.
- o_phase_est  out  S_PH  current estimator result.
- o_phase_update  out  1  one-cycle pulse when o_phase_est is rewritten.

Behaviour:
- Reset values: o_bit=0, o_valid=0, o_phase_est=0, o_phase_update=0. Phase counter, symbol counter and accumulators are 0; FSM is in IDLE.
- Phase counter r_cont:
  - Increments on each cycle with i_enable&&i_valid; wraps OS-1 -> 0.
  - Holds when i_valid=0.
  - Cleared when i_enable=0.
- Selected phase: sel = i_phase_mode ? i_phase_man : o_phase_est. sel is sampled combinationally each cycle; a change takes effect on the next kept sample.
- Slicing:
  - If i_enable&&i_valid&&r_cont==sel, then on the next edge o_valid=1 and o_bit=i_sample[S_IN-1].
  - Otherwise o_valid=0 and o_bit holds.
  - Latency is one clock.
- Magnitude: |x| is computed in S_IN bits unsigned. -2^(S_IN-1) maps to 2^(S_IN-1), with no saturation needed. The accumulator cannot overflow: max = 2^(S_IN-1) * 2^N_SYM_LOG2 < 2^S_ACC.
- Estimator FSM:
  - IDLE -> ACCUM when i_enable=1.
  - ACCUM: on each valid sample, acc[r_cont] += |i_sample|. The symbol counter increments when r_cont wraps OS-1 -> 0. When the counter reaches 2^N_SYM_LOG2 symbols (on that valid wrap sample), go to COMPARE.
  - COMPARE: exactly OS cycles of sequential argmax over acc[0..OS-1]. Strict ">" is used, so ties resolve to the lowest index. On the last cycle, o_phase_est is written, o_phase_update pulses next edge, accumulators and symbol counter clear, and the FSM returns to ACCUM.
  - The estimator runs in both modes.
- Samples arriving during COMPARE:
  - They are sliced normally.
  - They advance r_cont.
  - They are not accumulated.
- i_enable=0 in any state: FSM -> IDLE; counters and accumulators clear; o_valid=0; o_phase_est is retained.
- i_reset assertion mid-window or mid-COMPARE: all state returns to reset values immediately.
- i_valid gaps: they never advance r_cont or the symbol counter, and they never accumulate.

Decomposition:
- Shared package rx_pkg: OS, S_IN, derived S_PH/S_ACC, FSM state encoding (IDLE/ACCUM/COMPARE), and the magnitude function. OS and S_IN are shared with the TX filter so both ends agree.
- One sub-module, phase_energy_estimator: accumulators, symbol counter, FSM and argmax. It takes r_cont, the valid qualifier and |sample|, and returns o_phase_est and o_phase_update.
- The top level keeps the phase counter, the slicer and the mode mux.

Test Plan (OS=4, S_IN=10, N_SYM_LOG2=2):
- Manual phase 2, continuous valid, repeating {0,0,+100,0} -> o_valid every 4th cycle, one clock after the +100 sample, with o_bit=0. Same test with -100 -> o_bit=1.
- Auto mode, repeating {10,-10,10,-127} -> after 4 symbols plus 4 COMPARE cycles, o_phase_est=3 and o_phase_update pulses once. Subsequent o_valid outputs align with phase 3, with o_bit=1.
- Tie: all phases with |x|=50 -> o_phase_est=0. Then acc[2] ties acc[1] with others lower -> o_phase_est=1.
- Edge value: -512 on every sample -> no accumulator overflow; window acc=2048 per phase; o_bit=1.
- i_valid toggling 1010… -> r_cont and o_valid cadence match the continuous case counted in valid samples only; estimator result is identical.
- Drop i_enable mid-ACCUM -> next cycle o_valid=0, counters=0, o_phase_est unchanged. Assert i_reset during COMPARE -> all outputs 0, with no o_phase_update.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared receive-side definitions: oversampling geometry, sample width and helpers.
// OS and S_IN must track the TX polyphase filter so both ends agree on framing.
package rx_pkg;

    localparam int OS   = 4;
    localparam int S_IN = 10;
    localparam int S_PH = (OS > 1) ? $clog2(OS) : 1;

    localparam logic [S_PH-1:0] PH_LAST = S_PH'(OS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2
    } est_state_t;

    // Unsigned S_IN-bit result: the most negative input maps to 2^(S_IN-1) exactly.
    function automatic logic [S_IN-1:0] magnitude(input logic signed [S_IN-1:0] x);
        logic [S_IN-1:0] u;
        u = x;
        return x[S_IN-1] ? (~u + S_IN'(1)) : u;
    endfunction

endpackage

// File: rtl/rx_phase_slicer_estimator.sv
// Block-energy timing estimator: sums |sample| per phase over 2^N_SYM_LOG2 symbols,
// then runs an OS-cycle sequential argmax and publishes the winning phase.
module phase_energy_estimator
    import rx_pkg::*;
#(
    parameter int N_SYM_LOG2 = 10
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_valid,
    input  logic [S_PH-1:0] i_cont,
    input  logic [S_IN-1:0] i_mag,
    output logic [S_PH-1:0] o_phase_est,
    output logic            o_phase_update
);

    localparam int S_ACC = S_IN + N_SYM_LOG2;
    localparam logic [N_SYM_LOG2-1:0] SYM_LAST = '1;

    est_state_t r_state;
    est_state_t w_state_next;

    logic [S_ACC-1:0]      r_acc [OS];
    logic [N_SYM_LOG2-1:0] r_sym_cnt;
    logic [S_PH-1:0]       r_cmp_idx;
    logic [S_PH-1:0]       r_best_idx;
    logic [S_ACC-1:0]      r_best_val;

    logic             w_accum;
    logic             w_wrap;
    logic             w_window_done;
    logic             w_cmp;
    logic             w_cmp_last;
    logic             w_take;
    logic [S_ACC-1:0] w_cand;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (!i_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_ACCUM;
                ST_ACCUM:   if (w_window_done) w_state_next = ST_COMPARE;
                ST_COMPARE: if (r_cmp_idx == PH_LAST) w_state_next = ST_ACCUM;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wrap        = 1'b0;
        w_accum       = 1'b0;
        w_window_done = 1'b0;
        w_cmp         = 1'b0;
        w_cmp_last    = 1'b0;
        w_wrap        = i_valid && (i_cont == PH_LAST);
        w_accum       = i_enable && i_valid && (r_state == ST_ACCUM);
        w_window_done = w_accum && w_wrap && (r_sym_cnt == SYM_LAST);
        w_cmp         = i_enable && (r_state == ST_COMPARE);
        w_cmp_last    = w_cmp && (r_cmp_idx == PH_LAST);
    end

    // Strict '>' keeps the earlier index on ties; index 0 always seeds the search.
    assign w_cand = r_acc[r_cmp_idx];
    assign w_take = (r_cmp_idx == '0) || (w_cand > r_best_val);

    // NOTE: the accumulator array is only OS words, so it takes the async reset like any register.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < OS; i++) r_acc[i] <= '0;
            r_sym_cnt  <= '0;
            r_cmp_idx  <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (!i_enable || w_cmp_last) begin
            for (int i = 0; i < OS; i++) r_acc[i] <= '0;
            r_sym_cnt <= '0;
            r_cmp_idx <= '0;
        end else begin
            if (w_accum) begin
                r_acc[i_cont] <= r_acc[i_cont] + S_ACC'(i_mag);
                if (w_wrap) r_sym_cnt <= r_sym_cnt + N_SYM_LOG2'(1);
            end
            if (w_cmp) begin
                r_cmp_idx <= r_cmp_idx + S_PH'(1);
                if (w_take) begin
                    r_best_val <= w_cand;
                    r_best_idx <= r_cmp_idx;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_phase_est    <= '0;
            o_phase_update <= 1'b0;
        end else begin
            o_phase_update <= w_cmp_last;
            if (w_cmp_last) o_phase_est <= w_take ? r_cmp_idx : r_best_idx;
        end
    end

endmodule

// File: rtl/rx_phase_slicer.sv
// Receive phase slicer: keeps one of every OS filtered samples at the selected phase
// and slices it to a bit (negative -> 1); the sampling phase is manual or estimated.
module rx_phase_slicer
    import rx_pkg::*;
#(
    parameter int N_SYM_LOG2 = 10
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic signed [S_IN-1:0] i_sample,
    input  logic                   i_phase_mode,
    input  logic        [S_PH-1:0] i_phase_man,
    output logic                   o_bit,
    output logic                   o_valid,
    output logic        [S_PH-1:0] o_phase_est,
    output logic                   o_phase_update
);

    logic [S_PH-1:0] r_cont;
    logic [S_PH-1:0] w_sel;
    logic [S_IN-1:0] w_mag;
    logic            w_keep;

    assign w_sel  = i_phase_mode ? i_phase_man : o_phase_est;
    assign w_mag  = magnitude(i_sample);
    assign w_keep = i_enable && i_valid && (r_cont == w_sel);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cont <= '0;
        end else if (!i_enable) begin
            r_cont <= '0;
        end else if (i_valid) begin
            r_cont <= (r_cont == PH_LAST) ? '0 : r_cont + S_PH'(1);
        end
    end

    // o_bit holds its last decision between kept samples; o_valid marks fresh ones.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_valid <= 1'b0;
            o_bit   <= 1'b0;
        end else begin
            o_valid <= w_keep;
            if (w_keep) o_bit <= i_sample[S_IN-1];
        end
    end

    phase_energy_estimator #(
        .N_SYM_LOG2 (N_SYM_LOG2)
    ) u_estimator (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_cont         (r_cont),
        .i_mag          (w_mag),
        .o_phase_est    (o_phase_est),
        .o_phase_update (o_phase_update)
    );

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Scoreboard bench for rx_phase_slicer: the driver queues expected bits and phase updates,
// a negedge monitor pops and compares whenever the DUT presents o_valid or o_phase_update.
`timescale 1ns/1ps
module tb_rx_phase_slicer;
    import rx_pkg::*;

    localparam int NLOG = 2;

    typedef logic signed [S_IN-1:0] pat_t [OS];
    typedef struct {
        logic b;
        int   cyc;
    } exp_t;

    logic                   clock = 1'b0;
    logic                   i_reset;
    logic                   i_enable;
    logic                   i_valid;
    logic signed [S_IN-1:0] i_sample;
    logic                   i_phase_mode;
    logic        [S_PH-1:0] i_phase_man;
    logic                   o_bit;
    logic                   o_valid;
    logic        [S_PH-1:0] o_phase_est;
    logic                   o_phase_update;

    exp_t bit_q[$];
    int   phase_q[$];
    exp_t e_mon;
    int   p_mon;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_cont = 0;
    int   m_est  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rx_phase_slicer #(.N_SYM_LOG2(NLOG)) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_sample       (i_sample),
        .i_phase_mode   (i_phase_mode),
        .i_phase_man    (i_phase_man),
        .o_bit          (o_bit),
        .o_valid        (o_valid),
        .o_phase_est    (o_phase_est),
        .o_phase_update (o_phase_update)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (o_valid === 1'b1) begin
            if (bit_q.size() == 0) begin
                check("unexpected o_valid", 32'(o_valid), 0);
            end else begin
                e_mon = bit_q.pop_front();
                check("o_bit", 32'(o_bit), 32'(e_mon.b));
                check("o_valid cycle", cyc, e_mon.cyc);
            end
        end
        if (o_phase_update === 1'b1) begin
            if (phase_q.size() == 0) begin
                check("unexpected o_phase_update", 32'(o_phase_update), 0);
            end else begin
                p_mon = phase_q.pop_front();
                check("o_phase_est at update", 32'(o_phase_est), p_mon);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic signed [S_IN-1:0] s);
        int sel;
        exp_t e;
        sel      = i_phase_mode ? int'(i_phase_man) : m_est;
        i_valid  = 1'b1;
        i_sample = s;
        if (i_enable && m_cont == sel) begin
            e.b   = s[S_IN-1];
            e.cyc = cyc + 1;
            bit_q.push_back(e);
        end
        m_cont = (m_cont + 1) % OS;
        tick();
    endtask

    task automatic stream(input pat_t pat, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            drive(pat[m_cont]);
            if (gap) begin
                i_valid  = 1'b0;
                i_sample = '0;
                tick();
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic do_reset(input bit mode, input int man);
        i_valid = 1'b0;
        tick();
        i_reset      = 1'b0;
        i_enable     = 1'b0;
        i_sample     = '0;
        i_phase_mode = mode;
        i_phase_man  = man[S_PH-1:0];
        #1;
        check("reset o_bit", 32'(o_bit), 0);
        check("reset o_valid", 32'(o_valid), 0);
        check("reset o_phase_est", 32'(o_phase_est), 0);
        check("reset o_phase_update", 32'(o_phase_update), 0);
        tick();
        i_reset = 1'b1;
        tick();
        i_enable = 1'b1;
        tick();
        m_cont = 0;
        m_est  = 0;
    endtask

    // Run one full window plus COMPARE, expecting the given estimate on the final sample.
    task automatic window(input pat_t pat, input int est, input string tag);
        stream(pat, 4 * (1 << NLOG) + OS - 1, 1'b0);
        check({tag, " no early update"}, 32'(o_phase_update), 0);
        phase_q.push_back(est);
        stream(pat, 1, 1'b0);
        check({tag, " update pulse"}, 32'(o_phase_update), 1);
        check({tag, " o_phase_est"}, 32'(o_phase_est), est);
        m_est = est;
    endtask

    initial begin
        pat_t p;
        pat_t p2;
        i_reset      = 1'b0;
        i_enable     = 1'b0;
        i_valid      = 1'b0;
        i_sample     = '0;
        i_phase_mode = 1'b0;
        i_phase_man  = '0;

        // Manual phase 2, positive then negative pulse at that phase.
        do_reset(1'b1, 2);
        p = '{10'sd0, 10'sd0, 10'sd100, 10'sd0};
        stream(p, 12, 1'b0);
        do_reset(1'b1, 2);
        p = '{10'sd0, 10'sd0, -10'sd100, 10'sd0};
        stream(p, 12, 1'b0);

        // Auto mode: phase 3 carries the energy.
        do_reset(1'b0, 0);
        p = '{10'sd10, -10'sd10, 10'sd10, -10'sd127};
        window(p, 3, "auto");
        stream(p, 8, 1'b0);

        // Ties: all equal -> 0, then acc[1]==acc[2] highest -> 1.
        do_reset(1'b0, 0);
        p = '{10'sd50, -10'sd50, 10'sd50, -10'sd50};
        window(p, 0, "tie all");
        p2 = '{10'sd10, 10'sd40, 10'sd40, -10'sd20};
        window(p2, 1, "tie 1v2");

        // Extreme negative input: 2048 per phase, then phase 1 wins by 4.
        do_reset(1'b0, 0);
        p = '{-10'sd512, -10'sd512, -10'sd512, -10'sd512};
        window(p, 0, "edge all");
        p2 = '{-10'sd511, -10'sd512, -10'sd511, -10'sd511};
        window(p2, 1, "edge max");

        // Valid toggling 1010: COMPARE spans only two valid samples.
        do_reset(1'b0, 0);
        p = '{10'sd10, -10'sd10, 10'sd10, -10'sd127};
        stream(p, 4 * (1 << NLOG) + 1, 1'b1);
        check("gap no early update", 32'(o_phase_update), 0);
        phase_q.push_back(3);
        stream(p, 1, 1'b0);
        check("gap update pulse", 32'(o_phase_update), 1);
        check("gap o_phase_est", 32'(o_phase_est), 3);
        tick();
        m_est = 3;
        stream(p, 8, 1'b1);

        // Enable drop mid-ACCUM, then a fresh window must start from zero.
        do_reset(1'b0, 0);
        window(p, 3, "pre-drop");
        stream(p, 7, 1'b0);
        i_enable = 1'b0;
        i_valid  = 1'b1;
        i_sample = -10'sd127;
        tick();
        check("drop o_valid", 32'(o_valid), 0);
        check("drop o_phase_est held", 32'(o_phase_est), 3);
        check("drop o_phase_update", 32'(o_phase_update), 0);
        tick();
        i_enable = 1'b1;
        i_valid  = 1'b0;
        tick();
        m_cont = 0;
        p2 = '{-10'sd127, 10'sd10, -10'sd10, 10'sd10};
        window(p2, 0, "post-drop");

        // Async reset in the middle of COMPARE.
        do_reset(1'b0, 0);
        window(p, 3, "pre-rst");
        stream(p, 4 * (1 << NLOG) + 1, 1'b0);
        check("pre-rst o_bit", 32'(o_bit), 1);
        i_reset = 1'b0;
        #1;
        check("rst o_bit", 32'(o_bit), 0);
        check("rst o_valid", 32'(o_valid), 0);
        check("rst o_phase_est", 32'(o_phase_est), 0);
        check("rst o_phase_update", 32'(o_phase_update), 0);
        tick();
        tick();
        tick();
        check("rst hold o_phase_update", 32'(o_phase_update), 0);
        i_reset = 1'b1;
        tick();
        tick();

        check("bit queue drained", bit_q.size(), 0);
        check("phase queue drained", phase_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
